bcd_to_binary_4digit: RTL and testbench

BCD_TO_BINARY_4DIGIT -- requirements
Module: bcd_to_binary_4digit

---
 rtl/bcd_to_binary_4digit_if.sv | 24 ++
 rtl/bcd_to_binary_4digit.sv | 117 +++++++++++
 tb/tb_bcd_to_binary_4digit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_binary_4digit_if.sv
// Request/result bundle for the 4-digit BCD to binary converter.
// The master drives start and the digits; the slave (the converter) returns results.
interface bcd_to_binary_4digit_if;
  logic        start;
  logic [3:0]  thousands;
  logic [3:0]  hundreds;
  logic [3:0]  tens;
  logic [3:0]  ones;
  logic [13:0] binary_out;
  logic        fits_11bit;
  logic        done;
  logic        busy;
  logic        error;

  modport master (
    output start, thousands, hundreds, tens, ones,
    input  binary_out, fits_11bit, done, busy, error
  );

  modport slave (
    input  start, thousands, hundreds, tens, ones,
    output binary_out, fits_11bit, done, busy, error
  );
endinterface

// File: rtl/bcd_to_binary_4digit.sv
// Sequential 4-digit BCD to 14-bit binary converter using reverse double-dabble.
// Fixed latency: request in cycle 0, result posted in cycle 15; invalid digits post an error in cycle 1.
module bcd_to_binary_4digit (
  input  logic                          clk,
  input  logic                          reset,
  bcd_to_binary_4digit_if.slave         bus
);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  localparam logic [3:0] LAST_STEP = 4'd13;

  state_t      state;
  state_t      state_next;
  logic [3:0]  iter;
  logic [29:0] sr;
  logic [29:0] sr_step;
  logic        digits_valid;

  logic [13:0] binary_out_q;
  logic        fits_11bit_q;
  logic        error_q;

  assign digits_valid = (bus.thousands <= 4'd9) && (bus.hundreds <= 4'd9) &&
                        (bus.tens <= 4'd9) && (bus.ones <= 4'd9);

  // One reverse double-dabble step: shift right, then a nibble with its MSB set
  // (>= 8) has just received a bit worth 5, not 8, so it is corrected by 3.
  always_comb begin
    sr_step = {1'b0, sr[29:1]};
    for (int unsigned i = 0; i < 4; i++) begin
      if (sr_step[14 + 4*i + 3]) begin
        sr_step[14 + 4*i +: 4] = sr_step[14 + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = digits_valid ? CONV : DONE;
        end
      end
      CONV: begin
        if (iter == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iter         <= '0;
      sr           <= '0;
      binary_out_q <= '0;
      fits_11bit_q <= 1'b1;
      error_q      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            iter <= '0;
            sr   <= {bus.thousands, bus.hundreds, bus.tens, bus.ones, 14'd0};
            if (!digits_valid) begin
              binary_out_q <= '0;
              fits_11bit_q <= 1'b0;
              error_q      <= 1'b1;
            end
          end
        end
        CONV: begin
          sr   <= sr_step;
          iter <= iter + 4'd1;
          // Results are loaded from the final step so they are valid throughout DONE.
          if (iter == LAST_STEP) begin
            binary_out_q <= sr_step[13:0];
            fits_11bit_q <= (sr_step[13:11] == 3'd0);
            error_q      <= 1'b0;
          end
        end
        DONE: begin
          iter <= '0;
        end
        default: begin
          iter <= '0;
        end
      endcase
    end
  end

  assign bus.binary_out = binary_out_q;
  assign bus.fits_11bit = fits_11bit_q;
  assign bus.error      = error_q;

endmodule

// File: tb/tb_bcd_to_binary_4digit.sv
// Self-checking bench for bcd_to_binary_4digit: expected results are queued at request time
// and popped when done is observed.
module tb_bcd_to_binary_4digit;

  typedef struct {
    logic [13:0] value;
    logic        fits;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  exp_t sb[$];

  bcd_to_binary_4digit_if bus ();

  bcd_to_binary_4digit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] t, input logic [3:0] h,
                                 input logic [3:0] te, input logic [3:0] o);
    exp_t e;
    int   v;
    if (t > 9 || h > 9 || te > 9 || o > 9) begin
      e.value = '0;
      e.fits  = 1'b0;
      e.err   = 1'b1;
    end else begin
      v       = 1000 * int'(t) + 100 * int'(h) + 10 * int'(te) + int'(o);
      e.value = v[13:0];
      e.fits  = (v <= 2047);
      e.err   = 1'b0;
    end
    return e;
  endfunction

  // Assumes the caller is just past a rising edge; returns aligned the same way.
  task automatic convert(input logic [3:0] t, input logic [3:0] h,
                         input logic [3:0] te, input logic [3:0] o, output int lat);
    sb.push_back(model(t, h, te, o));
    bus.thousands = t;
    bus.hundreds  = h;
    bus.tens      = te;
    bus.ones      = o;
    bus.start     = 1'b1;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        bus.start     = 1'b0;
        bus.thousands = 4'($urandom_range(0, 9));
        bus.hundreds  = 4'($urandom_range(0, 9));
        bus.tens      = 4'($urandom_range(0, 9));
        bus.ones      = 4'($urandom_range(0, 9));
      end
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = n;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.thousands = 4'd1; bus.hundreds = 4'd2; bus.tens = 4'd3; bus.ones = 4'd4;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.binary_out !== 14'd0) begin fails++; $display("FAIL reset_binary_out got=%0d exp=0", bus.binary_out); end
    tests++; if (bus.fits_11bit !== 1'b1) begin fails++; $display("FAIL reset_fits got=%b exp=1", bus.fits_11bit); end
    tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    tests++; if (bus.error !== 1'b0) begin fails++; $display("FAIL reset_error got=%b exp=0", bus.error); end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic test_boundaries;
    logic [15:0] vec [5] = '{16'h0000, 16'h9999, 16'h2047, 16'h2048, 16'h1009};
    int   lat;
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      logic [15:0] d;
      d = vec[k];
      convert(d[15:12], d[11:8], d[7:4], d[3:0], lat);
      e = sb.pop_front();
      tests++; if (lat !== 15) begin fails++; $display("FAIL bound_latency digits=%h got=%0d exp=15", d, lat); end
      tests++; if (bus.binary_out !== e.value) begin fails++; $display("FAIL bound_value digits=%h got=%0d exp=%0d", d, bus.binary_out, e.value); end
      tests++; if (bus.fits_11bit !== e.fits) begin fails++; $display("FAIL bound_fits digits=%h got=%b exp=%b", d, bus.fits_11bit, e.fits); end
      tests++; if (bus.error !== e.err) begin fails++; $display("FAIL bound_error digits=%h got=%b exp=%b", d, bus.error, e.err); end
    end
  endtask

  task automatic test_error;
    int   lat;
    exp_t e;
    convert(4'd1, 4'hA, 4'd0, 4'd0, lat);
    e = sb.pop_front();
    tests++; if (lat !== 1) begin fails++; $display("FAIL err_latency got=%0d exp=1", lat); end
    tests++; if (bus.error !== e.err) begin fails++; $display("FAIL err_flag got=%b exp=%b", bus.error, e.err); end
    tests++; if (bus.binary_out !== e.value) begin fails++; $display("FAIL err_value got=%0d exp=%0d", bus.binary_out, e.value); end
    tests++; if (bus.fits_11bit !== e.fits) begin fails++; $display("FAIL err_fits got=%b exp=%b", bus.fits_11bit, e.fits); end
    convert(4'd0, 4'd0, 4'd1, 4'd2, lat);
    e = sb.pop_front();
    tests++; if (lat !== 15) begin fails++; $display("FAIL clr_latency got=%0d exp=15", lat); end
    tests++; if (bus.binary_out !== e.value) begin fails++; $display("FAIL clr_value got=%0d exp=%0d", bus.binary_out, e.value); end
    tests++; if (bus.error !== e.err) begin fails++; $display("FAIL clr_error got=%b exp=%b", bus.error, e.err); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.binary_out !== e.value) begin fails++; $display("FAIL hold_value got=%0d exp=%0d", bus.binary_out, e.value); end
    tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin fails++; $display("FAIL hold_idle busy=%b done=%b exp=0,0", bus.busy, bus.done); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_start;
    int   dones = 0;
    int   at = -1;
    exp_t e;
    sb.push_back(model(4'd1, 4'd2, 4'd3, 4'd4));
    bus.thousands = 4'd1; bus.hundreds = 4'd2; bus.tens = 4'd3; bus.ones = 4'd4;
    bus.start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      bus.start = (n == 5 || n == 15);
      if (n == 3) begin
        bus.thousands = 4'd9; bus.hundreds = 4'd9; bus.tens = 4'd9; bus.ones = 4'd9;
      end
      @(negedge clk);
      if (n == 1) begin
        tests++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL ign_busy got=%b exp=1", bus.busy); end
      end
      if (bus.done === 1'b1) begin
        dones++;
        if (at < 0) begin
          at = n;
          e = sb.pop_front();
          tests++; if (bus.binary_out !== e.value) begin fails++; $display("FAIL ign_value got=%0d exp=%0d", bus.binary_out, e.value); end
        end
      end
    end
    tests++; if (dones !== 1) begin fails++; $display("FAIL ign_done_count got=%0d exp=1", dones); end
    tests++; if (at !== 15) begin fails++; $display("FAIL ign_done_cycle got=%0d exp=15", at); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort;
    int   dones = 0;
    int   lat;
    exp_t e;
    bus.thousands = 4'd1; bus.hundreds = 4'd2; bus.tens = 4'd3; bus.ones = 4'd4;
    bus.start = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (n == 7) reset = 1'b1;
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    if (bus.done === 1'b1) dones++;
    tests++; if (dones !== 0) begin fails++; $display("FAIL abort_done got=%0d exp=0", dones); end
    tests++; if (bus.binary_out !== 14'd0) begin fails++; $display("FAIL abort_value got=%0d exp=0", bus.binary_out); end
    tests++; if (bus.fits_11bit !== 1'b1) begin fails++; $display("FAIL abort_fits got=%b exp=1", bus.fits_11bit); end
    tests++; if (bus.busy !== 1'b0 || bus.error !== 1'b0) begin fails++; $display("FAIL abort_flags busy=%b error=%b exp=0,0", bus.busy, bus.error); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    convert(4'd0, 4'd5, 4'd0, 4'd0, lat);
    e = sb.pop_front();
    tests++; if (lat !== 15) begin fails++; $display("FAIL post_reset_latency got=%0d exp=15", lat); end
    tests++; if (bus.binary_out !== e.value) begin fails++; $display("FAIL post_reset_value got=%0d exp=%0d", bus.binary_out, e.value); end
  endtask

  task automatic test_back_to_back;
    int   dones = 0;
    int   at [3] = '{-1, -1, -1};
    exp_t e;
    for (int k = 0; k < 3; k++) sb.push_back(model(4'd4, 4'd3, 4'd2, 4'd1));
    bus.thousands = 4'd4; bus.hundreds = 4'd3; bus.tens = 4'd2; bus.ones = 4'd1;
    bus.start = 1'b1;
    for (int n = 1; n <= 55; n++) begin
      @(posedge clk);
      #1;
      bus.start = (n < 47);
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (dones < 3) begin
          at[dones] = n;
          e = sb.pop_front();
          tests++; if (bus.binary_out !== e.value) begin fails++; $display("FAIL b2b_value idx=%0d got=%0d exp=%0d", dones, bus.binary_out, e.value); end
        end
        dones++;
      end
    end
    tests++; if (dones !== 3) begin fails++; $display("FAIL b2b_count got=%0d exp=3", dones); end
    for (int k = 0; k < 3; k++) begin
      tests++; if (at[k] !== 15 + 16 * k) begin fails++; $display("FAIL b2b_cycle idx=%0d got=%0d exp=%0d", k, at[k], 15 + 16 * k); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep;
    int   lat;
    exp_t e;
    for (int v = 0; v <= 10000; v += 37) begin
      int vv;
      vv = (v > 9999) ? 9999 : v;
      convert(4'(vv / 1000), 4'((vv / 100) % 10), 4'((vv / 10) % 10), 4'(vv % 10), lat);
      e = sb.pop_front();
      tests++;
      if (lat !== 15 || bus.binary_out !== e.value || bus.fits_11bit !== e.fits || bus.error !== 1'b0) begin
        fails++;
        $display("FAIL sweep v=%0d lat=%0d got=%0d/%b/%b exp=15 %0d/%b/0",
                 vv, lat, bus.binary_out, bus.fits_11bit, bus.error, e.value, e.fits);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.thousands = '0; bus.hundreds = '0; bus.tens = '0; bus.ones = '0;
    test_reset();
    test_boundaries();
    test_error();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_sweep();
    tests++; if (sb.size() !== 0) begin fails++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
